// File: rtl/fixed_divider_if.sv
// Purpose: start/busy/done handshake bundle for the 8.8 fixed-point divider.
// Latency: n/a (wires only).
// Backpressure: none; the requester waits for busy low / done before reusing the unit.
//
// Ports carried:
//   start    - request a division (requester -> divider)
//   num1     - dividend, fixed point (requester -> divider)
//   num2     - divisor, fixed point (requester -> divider)
//   busy     - iteration sequence in progress (divider -> requester)
//   done     - one-cycle completion pulse (divider -> requester)
//   result   - quotient, truncated toward zero (divider -> requester)
//   overflow - quotient integer part does not fit (divider -> requester)
//   div_zero - divisor was zero (divider -> requester)
interface fixed_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             div_zero;

    modport master (
        output start, num1, num2,
        input  busy, done, result, overflow, div_zero
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, result, overflow, div_zero
    );
endinterface

// File: rtl/fixed_divider.sv
// Purpose: sequential unsigned restoring divider for WIDTH-bit fixed point with FRAC fraction bits.
// Latency: WIDTH+FRAC edges from accepted start to done (1 edge for a zero divisor).
// Backpressure: start is taken only in IDLE/DONE; a start while busy is dropped, not queued.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, overrides everything including an in-flight division
//   dif  - slave side of fixed_divider_if (start/num1/num2 in; busy/done/result/overflow/div_zero out)
module fixed_divider #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic            clk,
    input  logic            rst,
    fixed_divider_if.slave  dif
);
    localparam int ITER = WIDTH + FRAC;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after ITER steps the register holds the full quotient.
    logic [ITER-1:0]  dq;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             dz_q;

    // One restoring step. The trial value is kept two bits wider than the
    // divisor so the borrow out of the subtraction is a clean "trial < divisor".
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_nxt;
    logic [ITER-1:0]  dq_nxt;

    always_comb begin
        trial   = {rem, dq[ITER-1]};
        diff    = trial - {2'b00, dvsr};
        q_bit   = ~diff[WIDTH+1];
        rem_nxt = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];
        dq_nxt  = {dq[ITER-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dq       <= '0;
            rem      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                    if (dif.start) begin
                        if (dif.num2 == '0) begin
                            // Zero divisor: report saturated result immediately.
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= '1;
                            ovf_q    <= 1'b1;
                            dz_q     <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy_q <= 1'b1;
                            dq     <= {dif.num1, {FRAC{1'b0}}};
                            dvsr   <= dif.num2;
                            rem    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dq  <= dq_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= dq_nxt[WIDTH-1:0];
                        ovf_q    <= |dq_nxt[ITER-1:WIDTH];
                        dz_q     <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign dif.busy     = busy_q;
    assign dif.done     = done_q;
    assign dif.result   = result_q;
    assign dif.overflow = ovf_q;
    assign dif.div_zero = dz_q;
endmodule

// File: tb/tb_fixed_divider.sv
// Purpose: self-checking bench for fixed_divider; expected results are queued at start and popped on done.
// Latency: checks 24-edge completion, 1-edge zero-divisor completion and back-to-back restart.
// Backpressure: checks that a start during CALC is dropped and that reset aborts a division.
module tb_fixed_divider;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             dz;
    } exp_t;

    logic clk;
    logic rst;
    fixed_divider_if #(.WIDTH(WIDTH)) dif();

    fixed_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division of the scaled dividend.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH+FRAC-1:0] d;
        logic [WIDTH+FRAC-1:0] q;
        if (b == 0) begin
            e.res = '1;
            e.ovf = 1'b1;
            e.dz  = 1'b1;
        end else begin
            d     = {a, {FRAC{1'b0}}};
            q     = d / {{FRAC{1'b0}}, b};
            e.res = q[WIDTH-1:0];
            e.ovf = |q[WIDTH+FRAC-1:WIDTH];
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    // Call just after the accepting edge; k counts edges after it.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (dif.busy) bcnt++;
            if (dif.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        @(negedge clk);
        dif.num1  = a;
        dif.num2  = b;
        dif.start = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(posedge clk);
        #1 dif.start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        launch(a, b, 1'b1);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, bcnt, exp_busy);
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;

        rst       = 1'b1;
        dif.start = 1'b0;
        dif.num1  = '0;
        dif.num2  = '0;

        // Scoreboard monitor: every done must match the oldest pending expectation.
        fork
            forever begin
                @(negedge clk);
                if (dif.done) begin
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result", dif.result, e.res);
                        chk("overflow", dif.overflow, e.ovf);
                        chk("div_zero", dif.div_zero, e.dz);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_result", dif.result, 0);
        chk("rst_ovf", dif.overflow, 0);
        chk("rst_dz", dif.div_zero, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run("exact", 16'h0300, 16'h0200, 24, 24);
        repeat (3) @(negedge clk);
        chk("hold_result", dif.result, 16'h0180);
        chk("hold_done", dif.done, 0);

        run("trunc", 16'h0100, 16'h0300, 24, 24);
        run("ovf",   16'hFF00, 16'h0080, 24, 24);
        run("dzero", 16'h1234, 16'h0000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom_range(1, 16'hFFFF));
            run("rand", a, b, 24, 24);
        end

        // Start during CALC is dropped; operand changes are ignored.
        launch(16'h0A00, 16'h0500, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        dif.start = 1'b1;
        dif.num1  = 16'h0100;
        dif.num2  = 16'h0100;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.num1  = 16'h7777;
        dif.num2  = 16'h0003;
        wait_done(lat, bcnt);
        chk("hs_lat", lat, 18);

        // Restart in the done cycle, no idle bubble.
        dif.num1  = 16'h0400;
        dif.num2  = 16'h0200;
        dif.start = 1'b1;
        sb.push_back(model(16'h0400, 16'h0200));
        @(posedge clk);
        #1 dif.start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_lat", lat, 24);
        chk("b2b_busy", bcnt, 24);

        // Reset at the 10th CALC edge aborts the division.
        launch(16'h0300, 16'h0200, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", dif.busy, 0);
        chk("abort_done", dif.done, 0);
        chk("abort_result", dif.result, 0);
        chk("abort_ovf", dif.overflow, 0);
        chk("abort_dz", dif.div_zero, 0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (dif.done) ndone++;
        end
        chk("abort_nodone", ndone, 0);

        run("post_rst", 16'h0300, 16'h0200, 24, 24);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
